// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around the SRAM port arbiter.
// slave is the arbiter's view; master is the core/memory environment driving it.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        stallreq;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output stallreq
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  stallreq
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Serialises fetch and data transactions onto one SRAM-like port, one outstanding at a time.
// Data wins arbitration unless fetch has been passed over STARVE_LIMIT times in a row.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic        owner;
  logic [3:0]  cnt;
  logic        l_wr;
  logic [3:0]  l_wstrb;
  logic [31:0] l_addr, l_wdata;
  logic        inst_pend, data_pend;
  logic        grant_d, grant_i;
  logic        i_aok, i_dok, d_aok, d_dok, m_req;

  assign grant_d = (state == IDLE) & bus.data_req & ~(bus.inst_req & (cnt == LIMIT));
  assign grant_i = (state == IDLE) & bus.inst_req & ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_req     = 1'b0;
    i_aok     = 1'b0;
    i_dok     = 1'b0;
    d_aok     = 1'b0;
    d_dok     = 1'b0;
    case (state)
      IDLE: if (grant_d | grant_i) state_nxt = REQ;
      REQ: begin
        m_req = 1'b1;
        if (bus.mem_addr_ok) begin
          i_aok     = ~owner;
          d_aok     = owner;
          state_nxt = WAIT;
        end
      end
      WAIT: if (bus.mem_data_ok) begin
        i_dok     = ~owner;
        d_dok     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetches go out as reads with zero strobes and zero store data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= 1'b0;
      cnt     <= '0;
      l_wr    <= 1'b0;
      l_wstrb <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (grant_d) begin
      owner   <= 1'b1;
      l_wr    <= bus.data_wr;
      l_wstrb <= bus.data_wstrb;
      l_addr  <= bus.data_addr;
      l_wdata <= bus.data_wdata;
      if (bus.inst_req && cnt != LIMIT) cnt <= cnt + 4'd1;
    end else if (grant_i) begin
      owner   <= 1'b0;
      cnt     <= '0;
      l_wr    <= 1'b0;
      l_wstrb <= '0;
      l_addr  <= bus.inst_addr;
      l_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_pend <= 1'b0;
      data_pend <= 1'b0;
    end else begin
      if (i_dok)             inst_pend <= 1'b0;
      else if (bus.inst_req) inst_pend <= 1'b1;
      if (d_dok)             data_pend <= 1'b0;
      else if (bus.data_req) data_pend <= 1'b1;
    end
  end

  assign bus.mem_req      = m_req;
  assign bus.mem_wr       = l_wr;
  assign bus.mem_wstrb    = l_wstrb;
  assign bus.mem_addr     = l_addr;
  assign bus.mem_wdata    = l_wdata;
  assign bus.inst_addr_ok = i_aok;
  assign bus.inst_data_ok = i_dok;
  assign bus.inst_rdata   = i_dok ? bus.mem_rdata : '0;
  assign bus.data_addr_ok = d_aok;
  assign bus.data_data_ok = d_dok;
  assign bus.data_rdata   = d_dok ? bus.mem_rdata : '0;

  // Gated by rst so the stall drops the instant reset is applied, even with a req still high.
  assign bus.stallreq = rst & (((bus.inst_req | inst_pend) & ~i_dok) |
                               ((bus.data_req | data_pend) & ~d_dok));
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data-access requester (EX/MEM).
- Serialises their transactions with one outstanding transaction at a time.
- Gives data accesses priority, with a starvation guard for fetch.
- Raises a stall request to CTRL while any requester's transaction is not yet complete. It sits between the core's stage logic and the external memory bridge.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants issued while inst_req is pending before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held high until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted by memory
- inst_data_ok  out  1  fetch data valid, one-cycle pulse
- inst_rdata  out  32  fetch read data, valid when inst_data_ok
- data_req  in  1  data request; held high until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted by memory
- data_data_ok  out  1  data response, one-cycle pulse (read data or write ack)
- data_rdata  out  32  load data, valid when data_data_ok
- mem_req  out  1  request to memory port
- mem_wr  out  1  latched write flag
- mem_wstrb  out  4  latched strobes; 0 for fetches
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data; 0 for fetches
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data
- stallreq  out  1  to CTRL: pipeline must hold

Behaviour:
- FSM states: IDLE, REQ, WAIT. Registered owner bit: 0 = inst, 1 = data. Latched request fields. Starvation counter cnt.
- Reset (rst low, async): state=IDLE, owner=0, cnt=0, all latched fields 0. All outputs 0 immediately, including mem_req.
- IDLE arbitration (sampled at clock edge, fields latched on grant):
  - data_req only → grant data.
  - inst_req only → grant inst.
  - Both high: grant data unless cnt==STARVE_LIMIT, in which case grant inst.
  - Neither high → stay IDLE.
  - Grant moves to REQ.
- Latency: the grant edge is followed by mem_req=1 in the next cycle. Minimum req-to-data_ok is 3 cycles with a zero-wait memory.
- cnt update, applied at grant:
  - data granted while inst_req=1 → cnt+1, saturating at STARVE_LIMIT.
  - inst granted → cnt=0.
  - data granted while inst_req=0 → cnt unchanged.
- REQ:
  - mem_req=1 and mem_* come from the latched fields, stable until accepted.
  - On mem_addr_ok, the owner's *_addr_ok is asserted combinationally in the same cycle, and state moves to WAIT.
  - mem_data_ok in REQ is ignored; memory never returns data in the accept cycle.
- WAIT:
  - mem_req=0.
  - On mem_data_ok, the owner's *_data_ok=1 and *_rdata=mem_rdata (combinational), and state moves to IDLE.
  - The non-owner's *_data_ok stays 0 and its *_rdata stays 0.
- No re-arbitration in the data_ok cycle; back-to-back transactions are separated by one IDLE cycle.
- Requester dropping req after grant but before addr_ok: the transaction still completes with the latched fields. Requesters are required to hold req and must not do this.
- Addresses are passed through unchanged; no alignment checking.
- Per-requester pending flag:
  - Set at the edge where req is high.
  - Cleared at the edge where that requester's data_ok is high.
- stallreq = (inst_req | inst_pend) & ~inst_data_ok | (data_req | data_pend) & ~data_data_ok. Combinational, no registered delay.
- Reset mid-transaction: everything is abandoned and pending flags are cleared. No response is ever produced for the abandoned request.

Test Plan:
- Single fetch, inst_req=1 at 0x BFC00000, memory acks addr_ok in REQ's first cycle and data_ok 1 cycle later with 0x24010001 → mem_req high one cycle; inst_data_ok pulse with inst_rdata=0x24010001 three cycles after request; stallreq low the cycle after.
- Simultaneous inst_req and data_req (read 0x80001000) → data transaction first with mem_addr=0x80001000 and mem_wstrb=0; fetch issued after one IDLE cycle; data_data_ok precedes inst_data_ok.
- Store (data_wr=1, wstrb=0x3, addr 0x80000004, wdata 0x1234ABCD) with memory stalling addr_ok 3 cycles → mem_* fields stay constant for all 4 REQ cycles; data_addr_ok pulses once.
- Starvation with STARVE_LIMIT=4: inst_req and data_req both held high continuously → grant order D,D,D,D,I,D,D,D,D,I; cnt returns to 0 after each I.
- Assert rst low while in WAIT for a data read → mem_req, stallreq and all *_ok outputs 0 immediately; after release, state IDLE; a late mem_data_ok produces no data_data_ok.
- Requester drops data_req while in REQ → transaction still issued and completed; data_data_ok pulses once.
